branch_redirect_ctrl: RTL and testbench
=======================================

BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC/target width in bits.
REQ-002 SHALL have parameter CNT_W, default 16, statistics counter width in bits.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ex_valid_i  input  1  EX stage holds a valid instruction.
REQ-006 SHALL have port ex_branch_i  input  1  EX instruction is a conditional branch (BEQ/BNE/BLT/BGE/BLTU/BGEU).
REQ-007 SHALL have port ex_jump_i  input  1  EX instruction is an unconditional jump (JAL/JALR).
REQ-008 SHALL have port branch_enable_i  input  1  branch-condition result from the branch compare unit.
REQ-009 SHALL have port ex_pred_taken_i  input  1  fetch predicted this instruction taken.
REQ-010 SHALL have port ex_pc_i  input  ADDR_W  PC of EX instruction.
REQ-011 SHALL have port ex_target_i  input  ADDR_W  taken target address.
REQ-012 SHALL have port redirect_ready_i  input  1  fetch accepts redirect this cycle.
REQ-013 SHALL have port clr_cnt_i  input  1  synchronous clear of both statistics counters.
REQ-014 SHALL have port stall_o  output  1  hold IF/ID/EX stages.
REQ-015 SHALL have port flush_o  output  1  kill IF/ID and ID/EX contents.
REQ-016 SHALL have port redirect_valid_o  output  1  redirect request to fetch.
REQ-017 SHALL have port redirect_pc_o  output  ADDR_W  corrected fetch PC.
REQ-018 SHALL have port branch_cnt_o  output  CNT_W  resolved branch/jump count.
REQ-019 SHALL have port mispredict_cnt_o  output  CNT_W  misprediction count.

Function
REQ-020 SHALL implement FSM states IDLE, FLUSH, WAIT; all outputs registered or decoded from state/registers only.
REQ-021 SHALL resolve only in IDLE when ex_valid_i=1 and (ex_branch_i or ex_jump_i)=1; EX inputs are ignored in FLUSH and WAIT.
REQ-022 SHALL compute actual_taken = ex_jump_i OR (ex_branch_i AND branch_enable_i); ex_jump_i dominates when both asserted.
REQ-023 SHALL flag mispredict when actual_taken != ex_pred_taken_i.
REQ-024 SHALL compute correct PC = ex_target_i if actual_taken, else ex_pc_i+4 truncated to ADDR_W (wraps modulo 2^ADDR_W).
REQ-025 SHALL on mispredict in cycle N latch correct PC into redirect_pc_o and enter FLUSH at N+1.
REQ-026 SHALL in FLUSH drive flush_o=1, stall_o=1, redirect_valid_o=1; flush_o is high for exactly one cycle per mispredict.
REQ-027 SHALL transition FLUSH->IDLE if redirect_ready_i=1, else FLUSH->WAIT.
REQ-028 SHALL in WAIT drive flush_o=0, stall_o=1, redirect_valid_o=1, and move to IDLE in the cycle after redirect_ready_i=1.
REQ-029 SHALL hold redirect_pc_o stable while redirect_valid_o=1; redirect_valid_o never drops before acceptance.
REQ-030 SHALL in IDLE drive stall_o=0, flush_o=0, redirect_valid_o=0; redirect_pc_o retains last value.
REQ-031 SHALL when correctly predicted stay in IDLE with no flush, stall or redirect.
REQ-032 SHALL increment branch_cnt_o once per resolution (REQ-021) and mispredict_cnt_o once per mispredict, both in cycle N.
REQ-033 SHALL saturate both counters at all-ones (no wrap).
REQ-034 SHALL give clr_cnt_i priority: clear and increment in same cycle yields 0.
REQ-035 SHALL accept a new resolution in the first IDLE cycle after a redirect handshake (back-to-back mispredicts allowed).

Reset
REQ-036 SHALL on rst_i=0 immediately force state IDLE, stall_o=0, flush_o=0, redirect_valid_o=0, redirect_pc_o=0, both counters=0, including mid-FLUSH/WAIT (pending redirect discarded).
REQ-037 SHALL resume resolution on the first rising clk_i edge after rst_i returns to 1.

Verification
REQ-038 BEQ, branch_enable_i=1, pred_taken=0, target=0x100 -> N+1: flush_o=1, redirect_valid_o=1, redirect_pc_o=0x100; counters 1/1.
REQ-039 BNE, branch_enable_i=0, pred_taken=1, pc=0xFFFFFFFC -> redirect_pc_o=0x00000000 (wrap); flush one cycle.
REQ-040 Mispredict with redirect_ready_i low 3 cycles -> WAIT; valid/pc stable; stall_o=1 four cycles; flush_o single pulse; IDLE after accept.
REQ-041 Correct prediction (JAL, pred_taken=1) -> no flush/stall/redirect; branch_cnt_o+1, mispredict_cnt_o unchanged.
REQ-042 rst_i low during WAIT -> redirect_valid_o and stall_o 0 without clock edge; counters 0.
REQ-043 CNT_W=4, 20 mispredicts, clr_cnt_i coincident with a mispredict -> saturates at 15; clear yields 0.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - EX-stage branch resolution, misprediction flush and fetch redirect control
// Drives the pipeline flush and redirect handshake, and keeps the branch and mispredict statistics.
module branch_redirect_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ex_valid_i,
  input  logic              ex_branch_i,
  input  logic              ex_jump_i,
  input  logic              branch_enable_i,
  input  logic              ex_pred_taken_i,
  input  logic [ADDR_W-1:0] ex_pc_i,
  input  logic [ADDR_W-1:0] ex_target_i,
  input  logic              redirect_ready_i,
  input  logic              clr_cnt_i,
  output logic              stall_o,
  output logic              flush_o,
  output logic              redirect_valid_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
  output logic [CNT_W-1:0]  branch_cnt_o,
  output logic [CNT_W-1:0]  mispredict_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state_q;
  state_t            state_d;
  logic              resolve;
  logic              actual_taken;
  logic              mispredict;
  logic [ADDR_W-1:0] correct_pc;

  // Resolution happens only in IDLE; anything in EX during FLUSH/WAIT is being killed anyway.
  always_comb begin
    resolve      = (state_q == IDLE) && ex_valid_i && (ex_branch_i || ex_jump_i);
    actual_taken = ex_jump_i || (ex_branch_i && branch_enable_i);
    mispredict   = resolve && (actual_taken != ex_pred_taken_i);
    correct_pc   = actual_taken ? ex_target_i : (ex_pc_i + ADDR_W'(4));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mispredict) state_d = FLUSH;
      FLUSH:   state_d = redirect_ready_i ? IDLE : WAIT;
      WAIT:    if (redirect_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Only loaded from IDLE, so the value is frozen for as long as the redirect is pending.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      redirect_pc_o <= '0;
    end else if (mispredict) begin
      redirect_pc_o <= correct_pc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      branch_cnt_o     <= '0;
      mispredict_cnt_o <= '0;
    end else if (clr_cnt_i) begin
      branch_cnt_o     <= '0;
      mispredict_cnt_o <= '0;
    end else begin
      if (resolve && (branch_cnt_o != CNT_MAX)) begin
        branch_cnt_o <= branch_cnt_o + 1'b1;
      end
      if (mispredict && (mispredict_cnt_o != CNT_MAX)) begin
        mispredict_cnt_o <= mispredict_cnt_o + 1'b1;
      end
    end
  end

  assign flush_o          = (state_q == FLUSH);
  assign stall_o          = (state_q != IDLE);
  assign redirect_valid_o = (state_q != IDLE);

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb/tb_branch_redirect_ctrl.sv - self-checking bench for branch_redirect_ctrl
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_branch, ex_jump, branch_en, ex_pred;
  logic [31:0] ex_pc, ex_target;
  logic        redirect_ready, clr_cnt;
  logic        stall, flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic [3:0]  branch_cnt, mis_cnt;

  branch_redirect_ctrl #(.ADDR_W(32), .CNT_W(4)) dut (
    .clk_i            (clk),
    .rst_i            (rst_n),
    .ex_valid_i       (ex_valid),
    .ex_branch_i      (ex_branch),
    .ex_jump_i        (ex_jump),
    .branch_enable_i  (branch_en),
    .ex_pred_taken_i  (ex_pred),
    .ex_pc_i          (ex_pc),
    .ex_target_i      (ex_target),
    .redirect_ready_i (redirect_ready),
    .clr_cnt_i        (clr_cnt),
    .stall_o          (stall),
    .flush_o          (flush),
    .redirect_valid_o (redirect_valid),
    .redirect_pc_o    (redirect_pc),
    .branch_cnt_o     (branch_cnt),
    .mispredict_cnt_o (mis_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        branch;
    logic        jump;
    logic        en;
    logic        pred;
    logic [31:0] pc;
    logic [31:0] target;
    int          ready_delay;
    logic        exp_mis;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t        vecs[8];
  vec_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          m_br   = 0;
  int          m_mis  = 0;
  logic [31:0] last_pc = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_branch_cnt"}, {28'h0, branch_cnt}, 32'(m_br));
    chk({tag, "_mis_cnt"}, {28'h0, mis_cnt}, 32'(m_mis));
  endtask

  // Drive one resolution at a negedge in IDLE, then follow the redirect handshake to IDLE.
  task automatic apply(input vec_t v, input logic clr);
    vec_t e;
    int   waited;
    int   stalls;
    int   flushes;
    ex_valid       = 1'b1;
    ex_branch      = v.branch;
    ex_jump        = v.jump;
    branch_en      = v.en;
    ex_pred        = v.pred;
    ex_pc          = v.pc;
    ex_target      = v.target;
    redirect_ready = (v.ready_delay == 0);
    clr_cnt        = clr;
    sb.push_back(v);
    @(negedge clk);
    ex_valid = 1'b0;
    clr_cnt  = 1'b0;
    e = sb.pop_front();
    if (clr) begin
      m_br  = 0;
      m_mis = 0;
    end else begin
      if (m_br < 15) m_br++;
      if (e.exp_mis && m_mis < 15) m_mis++;
    end
    chk_counters("resolve");
    if (e.exp_mis) begin
      chk("flush_first", {31'h0, flush}, 32'h1);
      chk("valid_first", {31'h0, redirect_valid}, 32'h1);
      chk("redirect_pc", redirect_pc, e.exp_pc);
      last_pc = e.exp_pc;
      waited  = 0;
      stalls  = 0;
      flushes = 0;
      while (redirect_valid === 1'b1 && waited < 20) begin
        stalls  += int'(stall);
        flushes += int'(flush);
        chk("pc_stable", redirect_pc, e.exp_pc);
        redirect_ready = (waited >= e.ready_delay);
        ex_valid  = 1'b1;
        ex_branch = 1'b0;
        ex_jump   = 1'b1;
        ex_pred   = 1'b0;
        ex_target = 32'hDEAD0000;
        @(negedge clk);
        waited++;
      end
      ex_valid       = 1'b0;
      ex_jump        = 1'b0;
      redirect_ready = 1'b0;
      chk("stall_cycles", 32'(stalls), 32'(e.ready_delay + 1));
      chk("flush_pulses", 32'(flushes), 32'h1);
      chk("idle_after_accept", {30'h0, stall, redirect_valid}, 32'h0);
      chk("pc_retained", redirect_pc, e.exp_pc);
      chk_counters("ignored_in_redirect");
    end else begin
      chk("no_redirect", {29'h0, flush, stall, redirect_valid}, 32'h0);
      chk("pc_unchanged", redirect_pc, last_pc);
    end
  endtask

  vec_t s;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h00000080, 32'h00000100, 0, 1'b1, 32'h00000100};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFC, 32'h00000200, 0, 1'b1, 32'h00000000};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h00001000, 32'h00002000, 0, 1'b0, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00001004, 32'h00003000, 0, 1'b0, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h00001008, 32'h00004000, 0, 1'b0, 32'h0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000100C, 32'h00003000, 3, 1'b1, 32'h00003000};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h00001010, 32'h00005000, 0, 1'b0, 32'h0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h00000040, 32'h00006000, 1, 1'b1, 32'h00000044};

    rst_n = 1'b0;
    ex_valid = 1'b0; ex_branch = 1'b0; ex_jump = 1'b0; branch_en = 1'b0; ex_pred = 1'b0;
    ex_pc = 32'h0; ex_target = 32'h0; redirect_ready = 1'b0; clr_cnt = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {29'h0, flush, stall, redirect_valid}, 32'h0);
    chk("reset_pc", redirect_pc, 32'h0);
    chk_counters("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) apply(vecs[i], 1'b0);

    // Saturation: 20 mispredicts on a 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      s = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h200 + 32'(i * 4), 32'h8000 + 32'(i * 16), 0, 1'b1,
            32'h8000 + 32'(i * 16)};
      apply(s, 1'b0);
    end
    chk("sat_branch", {28'h0, branch_cnt}, 32'hF);
    chk("sat_mis", {28'h0, mis_cnt}, 32'hF);

    s = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h300, 32'h9000, 0, 1'b1, 32'h9000};
    apply(s, 1'b1);
    s = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h400, 32'hA000, 0, 1'b1, 32'h404};
    apply(s, 1'b0);

    // Asynchronous reset in the middle of WAIT discards the pending redirect.
    ex_valid = 1'b1; ex_branch = 1'b0; ex_jump = 1'b1; ex_pred = 1'b0;
    ex_target = 32'hB000; redirect_ready = 1'b0;
    @(negedge clk);
    ex_valid = 1'b0; ex_jump = 1'b0;
    @(negedge clk);
    chk("wait_entered", {29'h0, flush, stall, redirect_valid}, 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ctrl", {29'h0, flush, stall, redirect_valid}, 32'h0);
    chk("async_rst_pc", redirect_pc, 32'h0);
    m_br = 0; m_mis = 0; last_pc = 32'h0;
    chk_counters("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    s = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h500, 32'hC000, 0, 1'b1, 32'hC000};
    apply(s, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
